// File: rtl/hex_display_scheduler_if.sv
// Bundle between a value source / display sink and the scan scheduler.
// Carries the enable, the nibble-word valid/ready handshake and the digit drive.
// The scheduler uses the slave modport; the source/board side uses master.
interface hex_display_scheduler_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic [4*DIGITS-1:0]   value_in;
    logic                  value_valid;
    logic                  value_ready;
    logic [4:0]            number;
    logic [DIGITS-1:0]     digit_en;
    logic                  frame_done;

    modport master (
        output enable, value_in, value_valid,
        input  value_ready, number, digit_en, frame_done
    );

    modport slave (
        input  enable, value_in, value_valid,
        output value_ready, number, digit_en, frame_done
    );
endinterface

// File: rtl/hex_display_scheduler.sv
// Scans DIGITS seven-segment positions through one shared hex encoder (macro HEX_SCHED_LZB_EN: leading-zero blanking).
// Latency: number/digit_en registered; a word accepted at frame end shows from the next cycle.
// Backpressure: value_ready only in IDLE or on the frame-end cycle, so a frame is never torn.
module hex_display_scheduler #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    hex_display_scheduler_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [4:0]          number_q, number_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                frame_done_q;
    logic                wrap;
    logic                frame_end;
    logic                load;
    logic                blank_d;
    logic [3:0]          nibble_d;

    // Handshake: accept only when idle or on the last cycle of a frame; never in reset.
    always_comb begin
        frame_end       = (state_q == SCAN) && (idx_q == IDX_LAST) && (presc_q == PRESC_LAST);
        bus.value_ready = !reset && ((state_q == IDLE) || frame_end);
        load            = bus.value_valid && bus.value_ready;
        value_d         = load ? bus.value_in : value_q;
    end

    // Next-state: scan state machine plus slot prescaler and digit index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        wrap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    presc_d = '0;
                end
            end
            SCAN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    presc_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                presc_d = '0;
            end
        endcase
    end

    // Output decode from next-state values so number/digit_en line up with idx/presc.
    always_comb begin
        nibble_d = value_d[{idx_d, 2'b00} +: 4];
`ifdef HEX_SCHED_LZB_EN
        // Blank digit k>0 when it and every more-significant nibble is zero.
        blank_d  = (idx_d != '0) && ((value_d >> {idx_d, 2'b00}) == '0);
`else
        blank_d  = 1'b0;
`endif
        number_d   = 5'h1F;
        digit_en_d = '1;
        if (state_d == SCAN) begin
            number_d = blank_d ? 5'h1F : {1'b0, nibble_d};
            // presc==0 is a dark guard cycle between digits to avoid ghosting.
            if (presc_d != '0) begin
                digit_en_d[idx_d] = 1'b0;
            end
        end
    end

    // State, holding register and registered display outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            presc_q      <= '0;
            value_q      <= '0;
            number_q     <= 5'h1F;
            digit_en_q   <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            presc_q      <= presc_d;
            value_q      <= value_d;
            number_q     <= number_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= wrap;
        end
    end

    assign bus.number     = number_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_hex_display_scheduler.sv
// Randomized bench for hex_display_scheduler with a time-based reference model.
// The model tracks "cycles since scan entry" and derives slot, guard and frame pulses arithmetically.
// Directed scenarios first, then a long random run with holding sources and rare resets.
module tb_hex_display_scheduler;
    localparam int D     = 4;
    localparam int S     = 4;
    localparam int FRAME = D * S;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hex_display_scheduler_if #(.DIGITS(D)) bus();

    hex_display_scheduler #(.DIGITS(D), .SCAN_DIV(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_scan = 1'b0;
    int          m_t    = 0;
    logic [15:0] m_val  = 16'h0;
    bit          m_xfer = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0d)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, check ready, advance model on posedge, check outputs.
    task automatic cycle(input logic r, input logic en, input logic vv, input logic [15:0] vin);
        logic       exp_rdy;
        int         slot;
        int         ph;
        logic [4:0] exp_num;
        logic [3:0] exp_den;
        logic       exp_fd;
        logic [3:0] nib;
        bit         blank;

        reset           = r;
        bus.enable      = en;
        bus.value_valid = vv;
        bus.value_in    = vin;
        #1;
        exp_rdy = !r && (!m_scan || ((m_t % FRAME) == FRAME - 1));
        check("value_ready", 32'(bus.value_ready), 32'(exp_rdy));

        @(posedge clk);
        m_xfer = 1'b0;
        if (r) begin
            m_scan = 1'b0;
            m_t    = 0;
            m_val  = 16'h0;
        end else begin
            if (vv && exp_rdy) begin
                m_val  = vin;
                m_xfer = 1'b1;
            end
            if (!m_scan) begin
                if (en) begin
                    m_scan = 1'b1;
                    m_t    = 0;
                end
            end else if (!en) begin
                m_scan = 1'b0;
            end else begin
                m_t++;
            end
        end

        @(negedge clk);
        exp_num = 5'h1F;
        exp_den = 4'hF;
        exp_fd  = 1'b0;
        if (m_scan) begin
            slot  = (m_t / S) % D;
            ph    = m_t % S;
            nib   = 4'((m_val >> (4 * slot)) & 16'hF);
            blank = 1'b0;
`ifdef HEX_SCHED_LZB_EN
            blank = (slot > 0) && ((m_val >> (4 * slot)) == 16'h0);
`endif
            exp_num = blank ? 5'h1F : {1'b0, nib};
            if (ph != 0) exp_den = ~(4'(1) << slot);
            exp_fd = (m_t > 0) && ((m_t % FRAME) == 0);
        end
        check("number",     32'(bus.number),     32'(exp_num));
        check("digit_en",   32'(bus.digit_en),   32'(exp_den));
        check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    endtask

    // Offer a word and hold it until the model says it was taken (bounded).
    task automatic offer(input logic [15:0] v, input int budget);
        bit taken = 1'b0;
        for (int i = 0; i < budget && !taken; i++) begin
            cycle(1'b0, bus.enable, 1'b1, v);
            taken = m_xfer;
        end
        check("xfer_in_budget", 32'(taken), 32'(1));
    endtask

    task automatic run(input logic en, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, en, 1'b0, 16'h0);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] full;
        int          k;
        full = 16'($urandom);
        k    = $urandom_range(0, 4);
        return full & (16'hFFFF >> (4 * k));
    endfunction

    initial begin
        logic        vv;
        logic        en;
        logic        r;
        logic [15:0] vin;
        bit          hit;

        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.value_valid = 1'b0;
        bus.value_in    = '0;
        @(negedge clk);

        // Reset, then scan with nothing loaded: all zeros, frame pulse every FRAME cycles
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b1, 16'hFFFF);
        run(1'b1, 40);

        // Load in IDLE, then enable
        run(1'b0, 2);
        bus.enable = 1'b0;
        offer(16'h12AF, 4);
        run(1'b1, 2 * FRAME);

        // Offer mid-frame: held until frame end, old value intact until then
        run(1'b1, 5);
        offer(16'h3333, 3 * FRAME);
        run(1'b1, FRAME + 3);

        // Drop enable while idx=2, then re-enable
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 16'h0);
            hit = m_scan && (((m_t / S) % D) == 2) && ((m_t % S) == 1);
        end
        check("reach_idx2", 32'(hit), 32'(1));
        run(1'b0, 3);
        run(1'b1, FRAME + 4);

        // Reset mid-frame with BEEF loaded
        run(1'b0, 1);
        bus.enable = 1'b0;
        offer(16'hBEEF, 4);
        run(1'b1, 7);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        run(1'b0, 2);
        run(1'b1, FRAME + 2);

        // Leading-zero patterns (blanked only when the macro is defined)
        run(1'b0, 1);
        bus.enable = 1'b0;
        offer(16'h0050, 4);
        run(1'b1, FRAME + 1);
        run(1'b0, 1);
        bus.enable = 1'b0;
        offer(16'h0000, 4);
        run(1'b1, FRAME + 1);

        // Enable dropped exactly on the frame-end cycle with a concurrent load
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 16'h0);
            hit = m_scan && ((m_t % FRAME) == FRAME - 1);
        end
        check("reach_frame_end", 32'(hit), 32'(1));
        cycle(1'b0, 1'b0, 1'b1, 16'hC0DE);
        check("load_on_drop", 32'(m_xfer), 32'(1));
        run(1'b1, FRAME + 1);

        // Random traffic
        vv  = 1'b0;
        en  = 1'b1;
        vin = 16'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) en = !en;
            r = ($urandom_range(0, 299) == 0);
            if (!vv && $urandom_range(0, 7) == 0) begin
                vv  = 1'b1;
                vin = rand_word();
            end
            cycle(r, en, vv, vin);
            if (m_xfer || r) vv = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
